// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory with registered load return.
// Define MEM_ARB_LOCK_EN to let a requester hold the memory for a locked burst of up to LOCK_MAX grants.
module mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              m_en_store,
  output logic [ADDR_W-1:0] m_addr_store,
  output logic [DATA_W-1:0] m_data_store,
  output logic              m_en_load,
  output logic [ADDR_W-1:0] m_addr_load,
  input  logic [DATA_W-1:0] m_data_load
);

  logic              last_b_q, last_b_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_win, b_win;

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  owner_e           owner_q;
  logic [CNT_W-1:0] cnt_q;
`else
  logic unused_lock;
  assign unused_lock = a_lock | b_lock;
`endif

  // An owning requester wins outright; otherwise the side not granted last wins a tie.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (!rst) begin
`ifdef MEM_ARB_LOCK_EN
      if (owner_q == OWN_A && a_req) begin
        a_win = 1'b1;
      end else if (owner_q == OWN_B && b_req) begin
        b_win = 1'b1;
      end else begin
`endif
        if (a_req && b_req) begin
          a_win = last_b_q;
          b_win = ~last_b_q;
        end else begin
          a_win = a_req;
          b_win = b_req;
        end
`ifdef MEM_ARB_LOCK_EN
      end
`endif
    end
  end

  always_comb begin
    m_en_store   = 1'b0;
    m_en_load    = 1'b0;
    m_addr_store = '0;
    m_addr_load  = '0;
    m_data_store = '0;
    if (a_win) begin
      m_en_store   = a_we;
      m_en_load    = ~a_we;
      m_addr_store = a_addr;
      m_addr_load  = a_addr;
      m_data_store = a_wdata;
    end else if (b_win) begin
      m_en_store   = b_we;
      m_en_load    = ~b_we;
      m_addr_store = b_addr;
      m_addr_load  = b_addr;
      m_data_store = b_wdata;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (a_win)      last_b_d = 1'b0;
    else if (b_win) last_b_d = 1'b1;
  end

  assign a_gnt    = a_win;
  assign b_gnt    = b_win;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
`ifdef MEM_ARB_LOCK_EN
      owner_q    <= OWN_NONE;
      cnt_q      <= '0;
`endif
    end else begin
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_win & ~a_we;
      b_rvalid_q <= b_win & ~b_we;
      if (a_win && !a_we) a_rdata_q <= m_data_load;
      if (b_win && !b_we) b_rdata_q <= m_data_load;
`ifdef MEM_ARB_LOCK_EN
      // The entry grant counts as the first of the burst, so a full burst is LOCK_MAX grants.
      case (owner_q)
        OWN_NONE: begin
          if (a_win && a_lock) begin
            owner_q <= OWN_A;
            cnt_q   <= CNT_W'(1);
          end else if (b_win && b_lock) begin
            owner_q <= OWN_B;
            cnt_q   <= CNT_W'(1);
          end
        end
        OWN_A: begin
          if (!a_req || !a_lock || cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OWN_B: begin
          if (!b_req || !b_lock || cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          owner_q <= OWN_NONE;
          cnt_q   <= '0;
        end
      endcase
`endif
    end
  end

endmodule
